// File: rtl/store_unit.sv
// Store path for the MEM stage: places SB/SH/SW data on the 32-bit write bus,
// drives byte enables and runs the req/ack handshake with a timeout.
module store_unit #(
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  funct,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam bit                TO_EN    = (TIMEOUT != 0);
  localparam int                LAST     = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LAST);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             addr_err_r, addr_err_s;
  logic             bus_err_r, bus_err_s;
  logic             mem_req_r, mem_req_s;
  logic [31:0]      mem_addr_r, mem_addr_s;
  logic [31:0]      mem_wdata_r, mem_wdata_s;
  logic [3:0]       mem_be_r, mem_be_s;

  function automatic logic is_illegal(input logic [1:0] f, input logic [1:0] a);
    case (f)
      2'b00:   is_illegal = 1'b0;
      2'b01:   is_illegal = a[0];
      2'b10:   is_illegal = (a != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] place_data(input logic [1:0] f, input logic [31:0] d);
    case (f)
      2'b00:   place_data = {4{d[7:0]}};
      2'b01:   place_data = {2{d[15:0]}};
      default: place_data = d;
    endcase
  endfunction

  // Replicated data stays the same in both byte orders; only the enables flip.
  function automatic logic [3:0] place_be(input logic [1:0] f, input logic [1:0] a);
    logic [3:0] be;
    case (f)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (BIG_ENDIAN != 0) begin
      place_be = {be[0], be[1], be[2], be[3]};
    end else begin
      place_be = be;
    end
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    addr_err_s  = 1'b0;
    bus_err_s   = 1'b0;
    mem_req_s   = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_be_s    = 4'b0000;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (is_illegal(funct, addr[1:0])) begin
            addr_err_s = 1'b1;
          end else begin
            state_s     = REQ;
            busy_s      = 1'b1;
            mem_req_s   = 1'b1;
            mem_addr_s  = {addr[31:2], 2'b00};
            mem_wdata_s = place_data(funct, wdata);
            mem_be_s    = place_be(funct, addr[1:0]);
            cnt_s       = {CNT_W{1'b0}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // Ack is checked first so an ack on the last allowed cycle still completes.
        if (mem_ack) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else if (TO_EN && (cnt_r == LAST_CNT)) begin
          state_s   = IDLE;
          bus_err_s = 1'b1;
          cnt_s     = cnt_r + CNT_ONE;
        end else begin
          state_s   = REQ;
          busy_s    = 1'b1;
          mem_req_s = 1'b1;
          mem_be_s  = mem_be_r;
          cnt_s     = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      addr_err_r  <= 1'b0;
      bus_err_r   <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      addr_err_r  <= addr_err_s;
      bus_err_r   <= bus_err_s;
      mem_req_r   <= mem_req_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_be_r    <= mem_be_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign addr_err  = addr_err_r;
  assign bus_err   = bus_err_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: little- and big-endian instances share stimulus and are
// checked every cycle against a transaction-level model, plus directed cases.
module tb_store_unit;

  localparam int TO = 15;

  logic        clock, reset, start, mem_ack;
  logic [1:0]  funct;
  logic [31:0] addr, wdata;

  logic        busy_l, done_l, aerr_l, berr_l, req_l;
  logic [31:0] maddr_l, mdata_l;
  logic [3:0]  be_l;
  logic        busy_b, done_b, aerr_b, berr_b, req_b;
  logic [31:0] maddr_b, mdata_b;
  logic [3:0]  be_b;

  int n_cmp = 0;
  int n_err = 0;

  store_unit #(.BIG_ENDIAN(0), .TIMEOUT(TO), .CNT_W(4)) dut_le (
    .clock(clock), .reset(reset), .start(start), .funct(funct), .addr(addr),
    .wdata(wdata), .busy(busy_l), .done(done_l), .addr_err(aerr_l),
    .bus_err(berr_l), .mem_req(req_l), .mem_addr(maddr_l), .mem_wdata(mdata_l),
    .mem_be(be_l), .mem_ack(mem_ack));

  store_unit #(.BIG_ENDIAN(1), .TIMEOUT(TO), .CNT_W(4)) dut_be (
    .clock(clock), .reset(reset), .start(start), .funct(funct), .addr(addr),
    .wdata(wdata), .busy(busy_b), .done(done_b), .addr_err(aerr_b),
    .bus_err(berr_b), .mem_req(req_b), .mem_addr(maddr_b), .mem_wdata(mdata_b),
    .mem_be(be_b), .mem_ack(mem_ack));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_aerr, m_berr;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_be_le, m_be_be;
  int          m_waited;

  function automatic logic model_illegal(input logic [1:0] f, input logic [31:0] a);
    int size;
    size = 1 << f;
    return (f == 2'd3) || ((a % size) != 0);
  endfunction

  function automatic void model_lanes(input logic [1:0] f, input logic [31:0] a,
                                      input logic [31:0] d, output logic [31:0] data,
                                      output logic [3:0] ble, output logic [3:0] bbe);
    int size, base;
    size = 1 << f;
    base = int'(a % 4);
    for (int i = 0; i < 4; i++) begin
      data[8*i +: 8] = d[8*(i % size) +: 8];
      ble[i]         = (i >= base) && (i < base + size);
      bbe[3-i]       = ble[i];
    end
  endfunction

  always @(posedge clock) begin
    logic [31:0] d;
    logic [3:0]  bl, bb;
    if (reset) begin
      m_valid  <= 1'b1;
      m_busy   <= 1'b0; m_done <= 1'b0; m_aerr <= 1'b0; m_berr <= 1'b0;
      m_addr   <= 32'd0; m_data <= 32'd0; m_be_le <= 4'd0; m_be_be <= 4'd0;
      m_waited <= 0;
    end else begin
      m_done <= 1'b0; m_aerr <= 1'b0; m_berr <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          if (model_illegal(funct, addr)) begin
            m_aerr <= 1'b1;
          end else begin
            model_lanes(funct, addr, wdata, d, bl, bb);
            m_busy   <= 1'b1;
            m_addr   <= addr - (addr % 4);
            m_data   <= d;
            m_be_le  <= bl;
            m_be_be  <= bb;
            m_waited <= 0;
          end
        end
      end else if (mem_ack) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_be_le <= 4'd0; m_be_be <= 4'd0;
      end else if (TO != 0 && m_waited + 1 == TO) begin
        m_busy <= 1'b0; m_berr <= 1'b1; m_be_le <= 4'd0; m_be_be <= 4'd0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("ctl_le", {27'd0, busy_l, done_l, aerr_l, berr_l, req_l},
          {27'd0, m_busy, m_done, m_aerr, m_berr, m_busy});
      chk("ctl_be", {27'd0, busy_b, done_b, aerr_b, berr_b, req_b},
          {27'd0, m_busy, m_done, m_aerr, m_berr, m_busy});
      chk("be_le", {28'd0, be_l}, {28'd0, m_be_le});
      chk("be_be", {28'd0, be_b}, {28'd0, m_be_be});
      if (m_busy) begin
        chk("addr_le", maddr_l, m_addr);
        chk("data_le", mdata_l, m_data);
        chk("addr_be", maddr_b, m_addr);
        chk("data_be", mdata_b, m_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives a one-cycle start; returns in the first cycle after it.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; funct = f; addr = a; wdata = d;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_and_check_done(input string name);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({name, "_done"}, {31'd0, done_l}, 32'd1);
    chk({name, "_req_off"}, {31'd0, req_l}, 32'd0);
  endtask

  initial begin
    logic [31:0] held_addr, held_data;
    logic [3:0]  exp_be;
    int          thr;
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; funct = 2'b00;
    addr = 32'd0; wdata = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_outs", {busy_l, done_l, aerr_l, berr_l, req_l, be_l, 23'd0}, 32'd0);
    chk("rst_addr", maddr_l, 32'd0);
    chk("rst_data", mdata_l, 32'd0);
    tick();

    // SB sweep with immediate ack
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 32'h0000_0100 + i, 32'hDEAD_BEEF);
      exp_be = 4'b0001 << i;
      chk("sb_req", {31'd0, req_l}, 32'd1);
      chk("sb_done_early", {31'd0, done_l}, 32'd0);
      chk("sb_addr", maddr_l, 32'h0000_0100);
      chk("sb_data", mdata_l, 32'hEFEF_EFEF);
      chk("sb_model_data", m_data, 32'hEFEF_EFEF);
      chk("sb_be_le", {28'd0, be_l}, {28'd0, exp_be});
      exp_be = 4'b1000 >> i;
      chk("sb_be_be", {28'd0, be_b}, {28'd0, exp_be});
      ack_and_check_done("sb");
      chk("sb_be_clear", {28'd0, be_l}, 32'd0);
    end

    // SH / SW placement
    issue(2'b01, 32'h0000_0202, 32'h1234_ABCD);
    chk("sh_data", mdata_l, 32'hABCD_ABCD);
    chk("sh_be_le", {28'd0, be_l}, 32'h0000_000C);
    chk("sh_be_be", {28'd0, be_b}, 32'h0000_0003);
    chk("sh_model_be", {28'd0, m_be_le}, 32'h0000_000C);
    ack_and_check_done("sh");
    issue(2'b10, 32'h0000_0200, 32'h1234_ABCD);
    chk("sw_data", mdata_l, 32'h1234_ABCD);
    chk("sw_be", {28'd0, be_l}, 32'h0000_000F);
    chk("sw_addr", maddr_l, 32'h0000_0200);
    ack_and_check_done("sw");

    // Misaligned / illegal requests
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      case (i)
        0:       issue(2'b01, 32'h0000_0201, 32'h1111_1111);
        1:       issue(2'b10, 32'h0000_0202, 32'h2222_2222);
        default: issue(2'b11, 32'h0000_0200, 32'h3333_3333);
      endcase
      chk("mis_aerr", {31'd0, aerr_l}, 32'd1);
      chk("mis_req", {31'd0, req_l}, 32'd0);
      tick();
      chk("mis_aerr_pulse", {31'd0, aerr_l}, 32'd0);
      chk("mis_no_done", {31'd0, done_l}, 32'd0);
      mem_ack = 1'b0;
    end

    // Ack delayed 5 cycles: six stable REQ cycles
    issue(2'b10, 32'h0000_0500, 32'hCAFE_F00D);
    held_addr = maddr_l; held_data = mdata_l;
    for (int j = 1; j <= 5; j++) begin
      chk("stall_req", {31'd0, req_l}, 32'd1);
      chk("stall_addr", maddr_l, held_addr);
      chk("stall_data", mdata_l, held_data);
      tick();
    end
    chk("stall_req6", {31'd0, req_l}, 32'd1);
    ack_and_check_done("stall");

    // No ack: bus_err in the 16th cycle after mem_req rises
    issue(2'b10, 32'h0000_0600, 32'h0BAD_0BAD);
    for (int j = 1; j <= TO; j++) begin
      chk("to_req", {31'd0, req_l}, 32'd1);
      chk("to_no_err", {31'd0, berr_l}, 32'd0);
      tick();
    end
    chk("to_berr", {31'd0, berr_l}, 32'd1);
    chk("to_req_off", {31'd0, req_l}, 32'd0);
    chk("to_busy_off", {31'd0, busy_l}, 32'd0);
    tick();
    chk("to_berr_pulse", {31'd0, berr_l}, 32'd0);

    // Ack on the last allowed REQ cycle wins over timeout
    issue(2'b10, 32'h0000_0700, 32'h7777_7777);
    for (int j = 1; j < TO; j++) tick();
    chk("late_req", {31'd0, req_l}, 32'd1);
    ack_and_check_done("late");
    chk("late_no_berr", {31'd0, berr_l}, 32'd0);

    // start held through REQ gives a single store
    start = 1'b1; funct = 2'b10; addr = 32'h0000_0300; wdata = 32'h3030_3030;
    tick(); tick(); tick();
    chk("hold_req", {31'd0, req_l}, 32'd1);
    mem_ack = 1'b1;
    tick();
    start = 1'b0; mem_ack = 1'b0;
    chk("hold_done", {31'd0, done_l}, 32'd1);
    tick();
    chk("hold_single", {31'd0, req_l}, 32'd0);

    // New start during the done cycle
    issue(2'b00, 32'h0000_0401, 32'h0000_00A5);
    ack_and_check_done("b2b_first");
    issue(2'b01, 32'h0000_0402, 32'h0000_5A5A);
    chk("b2b_req", {31'd0, req_l}, 32'd1);
    chk("b2b_data", mdata_l, 32'h5A5A_5A5A);
    ack_and_check_done("b2b_second");

    // Reset held two cycles during REQ
    issue(2'b10, 32'h0000_0800, 32'h8888_8888);
    tick();
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("rreq_outs", {27'd0, busy_l, done_l, aerr_l, berr_l, req_l}, 32'd0);
    end
    reset = 1'b0;
    tick();
    chk("rreq_after", {busy_l, done_l, aerr_l, berr_l, req_l, be_l, 23'd0}, 32'd0);
    chk("rreq_addr", maddr_l, 32'd0);

    // Randomized traffic, varying ack likelihood per segment
    thr = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) thr = ((c / 500) % 3 == 0) ? 4 : (((c / 500) % 3 == 1) ? 1 : 0);
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 2) == 0);
      funct   = 2'($urandom_range(0, 3));
      addr    = $urandom;
      wdata   = $urandom;
      mem_ack = ($urandom_range(0, 7) < thr);
      tick();
    end
    reset = 1'b0; start = 1'b0; mem_ack = 1'b1;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-path counterpart of the load-path extenders in mips32.
- Takes a store request (SB/SH/SW) from the MEM stage and narrows/replicates the register data onto the 32-bit data-memory write bus.
- Generates byte enables and runs a req/ack handshake to data memory.
- Flags misaligned stores and memory timeouts so the pipeline can stall or raise an exception.

Parameters:
- BIG_ENDIAN, 0, byte-lane order: 0 = little-endian (lane 0 = addr[1:0]==0), 1 = big-endian (lane 3 = addr[1:0]==0).
- TIMEOUT, 15, cycles in REQ without mem_ack before bus_err; 0 disables the timeout.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  store request; sampled only in IDLE.
- funct  in  2  00 = SB, 01 = SH, 10 = SW, 11 = reserved (illegal).
- addr  in  32  byte address of the store.
- wdata  in  32  register data (rt) to store.
- busy  out  1  high while state is REQ; pipeline stall.
- done  out  1  one-cycle pulse, store completed.
- addr_err  out  1  one-cycle pulse, misaligned address or illegal funct.
- bus_err  out  1  one-cycle pulse, memory timeout.
- mem_req  out  1  write request to data memory.
- mem_addr  out  32  word address {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-placed write data.
- mem_be  out  4  byte enables; bit i = lane i = mem_wdata[8i+7:8i].
- mem_ack  in  1  memory accepted the write.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, addr_err, bus_err, mem_req, mem_be, mem_addr, mem_wdata all 0 and the counter is cleared at the next edge.
  - Reset in REQ drops mem_req at that edge; no done or err pulse.
- States: IDLE, REQ. All outputs are registered.
- IDLE, start=1:
  - Illegal request: funct=11, or SH with addr[0]=1, or SW with addr[1:0]!=0.
    - addr_err=1 for the next cycle only.
    - State stays IDLE; mem_req stays 0.
  - Legal request:
    - Next cycle: state REQ, mem_req=1, busy=1.
    - mem_addr, mem_wdata and mem_be are loaded from the sampled inputs.
    - Counter cleared.
- IDLE with start=0: nothing happens; mem_ack is ignored in IDLE.
- Lane placement, little-endian (a = addr[1:0]):
  - SB: wdata = {4{wdata[7:0]}}, be = 0001 << a.
  - SH: wdata = {2{wdata[15:0]}}, be = 0011 << (2*a[1]).
  - SW: wdata as-is, be = 1111.
- BIG_ENDIAN=1: mem_be bit-reversed (be[i] -> be[3-i]). Data replication is unchanged, so the enables alone select the lanes.
- REQ handshake:
  - mem_req, mem_addr, mem_wdata and mem_be hold stable until mem_ack is sampled high.
  - mem_ack is valid in the first REQ cycle.
- REQ with mem_ack=1:
  - Next cycle: state IDLE, mem_req=0, busy=0, done=1 for one cycle.
  - mem_be returns to 0.
- REQ with mem_ack=0:
  - Counter increments.
  - If TIMEOUT!=0 and counter==TIMEOUT-1: next cycle state IDLE, mem_req=0, busy=0, bus_err=1 for one cycle.
- Simultaneous ack and timeout in the same cycle: ack wins; done, no bus_err.
- start while in REQ: ignored, not queued.
- start in the cycle where done or an err pulse is high: accepted, since state is already IDLE. This gives back-to-back stores.
- Latency: start (cycle 0), mem_req (cycle 1), ack in cycle k >= 1, done in cycle k+1. Minimum 2 cycles from start to done.
- Pulse exclusivity: done, addr_err and bus_err are never high in the same cycle.

Test Plan:
- Reset: hold reset 2 cycles during REQ -> mem_req=0, busy=0, no pulses; all outputs 0 after release.
- SB sweep, little-endian: addr=0x100..0x103, wdata=0xDEADBEEF, ack at first REQ cycle ->
  - mem_addr=0x100, mem_wdata=0xEFEFEFEF.
  - mem_be = 0001, 0010, 0100, 1000.
  - done exactly 2 cycles after each start.
- SH/SW placement:
  - SH addr=0x202, wdata=0x1234ABCD -> mem_wdata=0xABCDABCD, be=1100.
  - SW addr=0x200 -> be=1111, mem_wdata=0x1234ABCD.
  - BIG_ENDIAN=1 rerun -> SH be=0011, SB addr=...0 be=1000.
- Misalignment: SH addr=0x201, SW addr=0x202, funct=11 -> addr_err pulse 1 cycle after each start; mem_req never asserts; no done.
- Handshake stall and timeout:
  - ack delayed 5 cycles -> outputs stable for 6 REQ cycles, done the cycle after ack.
  - No ack with TIMEOUT=15 -> bus_err in the 16th cycle after mem_req rises; mem_req=0 in the same cycle.
- Corner events:
  - Ack exactly on cycle TIMEOUT-1 -> done, no bus_err.
  - start held high through REQ -> single store only.
  - New start during the done cycle -> mem_req re-asserts the next cycle.
